// File: rtl/bus_memory_slave.sv
// On-chip SRAM slave decoding a fixed address window; serves single/burst reads
// and writes over the begin/end/data_valid/busy/error bus handshake.
module bus_memory_slave #(
   parameter logic [31:0] BASE_ADDRESS = 32'h5000_0000,
   parameter int          ADDR_WIDTH   = 10
) (
   input  logic        clock,
   input  logic        n_reset,
   input  logic        begin_transactionIN,
   input  logic [31:0] address_dataIN,
   input  logic [3:0]  byte_enableIN,
   input  logic [7:0]  burst_sizeIN,
   input  logic        read_n_writeIN,
   input  logic        data_validIN,
   input  logic        end_transactionIN,
   input  logic        busyIN,
   output logic [31:0] address_dataOUT,
   output logic        data_validOUT,
   output logic        end_transactionOUT,
   output logic        busyOUT,
   output logic        errorOUT
);
   typedef enum logic [2:0] {IDLE, ERR, RD_ADDR, RD_DATA, RD_END, WR} state_t;

   localparam int DEPTH = 1 << ADDR_WIDTH;
   // sum width is generous so index + burst_size can never wrap
   localparam int SW    = ADDR_WIDTH + 9;

   state_t                state, next_state;
   logic [ADDR_WIDTH-1:0] idx, start_idx, mem_idx;
   logic [3:0]            be_q;
   logic [7:0]            bsize_q;
   logic [8:0]            cnt;
   logic [SW-1:0]         end_idx;
   logic [31:0]           mem [DEPTH];
   logic [31:0]           rdata, lane_mask;
   logic                  hit, accept, last, wr_en, rd_en;

   assign start_idx = address_dataIN[ADDR_WIDTH+1:2];
   assign end_idx   = SW'(start_idx) + SW'(burst_sizeIN);
   assign hit       = (address_dataIN[31:ADDR_WIDTH+2] == BASE_ADDRESS[31:ADDR_WIDTH+2]) &&
                      (address_dataIN[1:0] == 2'b00) && (end_idx <= SW'(DEPTH-1));

   assign accept    = (state == RD_DATA) && !busyIN;
   assign last      = (cnt == {1'b0, bsize_q});
   assign wr_en     = (state == WR) && data_validIN && (cnt <= {1'b0, bsize_q});
   // next word is fetched on the accepting cycle so beats stream back-to-back
   assign rd_en     = (state == RD_ADDR) || (accept && !last);
   assign mem_idx   = (state == RD_DATA) ? idx + ADDR_WIDTH'(1) : idx;
   assign lane_mask = {{8{be_q[3]}}, {8{be_q[2]}}, {8{be_q[1]}}, {8{be_q[0]}}};

   always_ff @(posedge clock or negedge n_reset) begin
      if (!n_reset) state <= IDLE;
      else          state <= next_state;
   end

   always_comb begin
      next_state = state;
      case (state)
         IDLE:    if (begin_transactionIN)
                     next_state = !hit ? ERR : (read_n_writeIN ? RD_ADDR : WR);
         ERR:     next_state = IDLE;
         RD_ADDR: next_state = end_transactionIN ? IDLE : RD_DATA;
         RD_DATA: if (end_transactionIN)     next_state = IDLE;
                  else if (accept && last)   next_state = RD_END;
         RD_END:  next_state = IDLE;
         WR:      if (end_transactionIN)     next_state = IDLE;
         default: next_state = IDLE;
      endcase
   end

   always_comb begin
      address_dataOUT    = '0;
      data_validOUT      = 1'b0;
      end_transactionOUT = 1'b0;
      busyOUT            = 1'b0;
      errorOUT           = 1'b0;
      case (state)
         ERR:     errorOUT = 1'b1;
         RD_DATA: begin
            data_validOUT   = 1'b1;
            address_dataOUT = rdata & lane_mask;
         end
         RD_END:  end_transactionOUT = 1'b1;
         default: ;
      endcase
   end

   always_ff @(posedge clock or negedge n_reset) begin
      if (!n_reset) begin
         idx     <= '0;
         be_q    <= '0;
         bsize_q <= '0;
         cnt     <= '0;
      end else if (state == IDLE && begin_transactionIN) begin
         idx     <= start_idx;
         be_q    <= byte_enableIN;
         bsize_q <= burst_sizeIN;
         cnt     <= '0;
      end else if (accept || wr_en) begin
         idx     <= idx + ADDR_WIDTH'(1);
         cnt     <= cnt + 9'd1;
      end
   end

   // memory contents survive reset; rdata only shows in RD_DATA
   always_ff @(posedge clock) begin
      if (wr_en)
         for (int b = 0; b < 4; b++)
            if (be_q[b]) mem[mem_idx][8*b +: 8] <= address_dataIN[8*b +: 8];
      if (rd_en) rdata <= mem[mem_idx];
   end
endmodule

// File: tb/tb_bus_memory_slave.sv
// Directed bench for bus_memory_slave: table of single-beat ops plus burst,
// stall, overrun, abort and async-reset sequences.
module tb_bus_memory_slave;
   logic        clock = 1'b0;
   logic        n_reset;
   logic        begin_transactionIN, read_n_writeIN, data_validIN, end_transactionIN, busyIN;
   logic [31:0] address_dataIN;
   logic [3:0]  byte_enableIN;
   logic [7:0]  burst_sizeIN;
   logic [31:0] address_dataOUT;
   logic        data_validOUT, end_transactionOUT, busyOUT, errorOUT;

   bus_memory_slave dut (
      .clock(clock), .n_reset(n_reset),
      .begin_transactionIN(begin_transactionIN), .address_dataIN(address_dataIN),
      .byte_enableIN(byte_enableIN), .burst_sizeIN(burst_sizeIN),
      .read_n_writeIN(read_n_writeIN), .data_validIN(data_validIN),
      .end_transactionIN(end_transactionIN), .busyIN(busyIN),
      .address_dataOUT(address_dataOUT), .data_validOUT(data_validOUT),
      .end_transactionOUT(end_transactionOUT), .busyOUT(busyOUT), .errorOUT(errorOUT));

   always #5 clock = ~clock;

   typedef struct {
      bit          rd;
      logic [31:0] addr;
      logic [3:0]  be;
      logic [7:0]  bs;
      logic [31:0] wdata;
      bit          exp_err;
      logic [31:0] exp_data;
   } vec_t;

   vec_t        vecs[17];
   logic [31:0] rbuf[256];
   logic [31:0] wbuf[256];
   int          tests = 0, fails = 0;
   int          n, vcyc, first_cyc, ends, end_cyc, errs, err_cyc;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clock);
      #1;
   endtask

   task automatic idle_inputs();
      begin_transactionIN = 0; read_n_writeIN = 0; data_validIN = 0;
      end_transactionIN = 0; busyIN = 0; address_dataIN = 0;
      byte_enableIN = 0; burst_sizeIN = 0;
   endtask

   // write nb beats from wbuf; end_transactionIN rides on the last beat
   task automatic wr(input logic [31:0] a, input logic [3:0] be, input logic [7:0] bs, input int nb);
      errs = 0;
      begin_transactionIN = 1; address_dataIN = a; byte_enableIN = be;
      burst_sizeIN = bs; read_n_writeIN = 0;
      step();
      begin_transactionIN = 0;
      for (int i = 0; i < nb; i++) begin
         data_validIN = 1; address_dataIN = wbuf[i]; end_transactionIN = (i == nb - 1);
         check("wr_busy", busyOUT, 0);
         if (errorOUT) errs++;
         step();
      end
      idle_inputs();
      step();
   endtask

   // read with per-data-phase-cycle busy mask; optional abort after beat abort_after
   task automatic rd(input logic [31:0] a, input logic [3:0] be, input logic [7:0] bs,
                     input logic [31:0] busy_mask, input int abort_after);
      logic [31:0] prev;
      bit          prev_stall;
      int          dp;
      n = 0; vcyc = 0; first_cyc = -1; ends = 0; end_cyc = -1; errs = 0; err_cyc = -1;
      prev_stall = 0; prev = 0;
      begin_transactionIN = 1; address_dataIN = a; byte_enableIN = be;
      burst_sizeIN = bs; read_n_writeIN = 1;
      step();
      begin_transactionIN = 0; address_dataIN = 0;
      for (int c = 1; c < int'(bs) + 40; c++) begin
         dp = c - 2;
         busyIN = (dp >= 0 && dp < 32) ? busy_mask[dp] : 1'b0;
         end_transactionIN = 0;
         if (prev_stall) check("stall_valid", data_validOUT, 1);
         if (data_validOUT) begin
            vcyc++;
            if (first_cyc < 0) first_cyc = c;
            if (prev_stall) check("stall_hold", address_dataOUT, prev);
            if (!busyIN) begin
               rbuf[n] = address_dataOUT;
               n++;
               if (n == abort_after) end_transactionIN = 1;
            end
            prev_stall = busyIN;
            prev = address_dataOUT;
         end else prev_stall = 0;
         if (end_transactionOUT) begin ends++; end_cyc = c; end
         if (errorOUT) begin errs++; err_cyc = c; end
         step();
      end
      idle_inputs();
   endtask

   initial begin
      vecs[0]  = '{0, 32'h5000_0010, 4'hF, 8'd0, 32'hDEAD_BEEF, 0, 32'h0};
      vecs[1]  = '{1, 32'h5000_0010, 4'hF, 8'd0, 32'h0,        0, 32'hDEAD_BEEF};
      vecs[2]  = '{0, 32'h5000_0020, 4'hF, 8'd0, 32'hFFFF_FFFF, 0, 32'h0};
      vecs[3]  = '{0, 32'h5000_0020, 4'h5, 8'd0, 32'h0000_0000, 0, 32'h0};
      vecs[4]  = '{1, 32'h5000_0020, 4'hF, 8'd0, 32'h0,        0, 32'hFF00_FF00};
      vecs[5]  = '{1, 32'h5000_0020, 4'h3, 8'd0, 32'h0,        0, 32'h0000_FF00};
      vecs[6]  = '{0, 32'h5000_0030, 4'hF, 8'd0, 32'hA5A5_A5A5, 0, 32'h0};
      vecs[7]  = '{0, 32'h5000_0030, 4'h0, 8'd0, 32'h1234_5678, 0, 32'h0};
      vecs[8]  = '{1, 32'h5000_0030, 4'hF, 8'd0, 32'h0,        0, 32'hA5A5_A5A5};
      vecs[9]  = '{0, 32'h5000_0FFC, 4'hF, 8'd0, 32'hCAFE_F00D, 0, 32'h0};
      vecs[10] = '{1, 32'h5000_0FFC, 4'hF, 8'd0, 32'h0,        0, 32'hCAFE_F00D};
      vecs[11] = '{1, 32'h6000_0000, 4'hF, 8'd0, 32'h0,        1, 32'h0};
      vecs[12] = '{1, 32'h5000_0002, 4'hF, 8'd0, 32'h0,        1, 32'h0};
      vecs[13] = '{1, 32'h5000_0FFC, 4'hF, 8'd1, 32'h0,        1, 32'h0};
      vecs[14] = '{0, 32'h5000_1010, 4'hF, 8'd0, 32'h0000_0000, 1, 32'h0};
      vecs[15] = '{1, 32'h4FFF_FFFC, 4'hF, 8'd0, 32'h0,        1, 32'h0};
      vecs[16] = '{1, 32'h5000_0010, 4'hF, 8'd0, 32'h0,        0, 32'hDEAD_BEEF};

      idle_inputs();
      n_reset = 0;
      #12;
      check("reset_outs", {address_dataOUT, data_validOUT, end_transactionOUT, busyOUT, errorOUT}, 0);
      n_reset = 1;
      step();

      foreach (vecs[i]) begin
         if (!vecs[i].rd) begin
            wbuf[0] = vecs[i].wdata;
            wr(vecs[i].addr, vecs[i].be, vecs[i].bs, 1);
            check($sformatf("v%0d_wr_err", i), errs, vecs[i].exp_err);
         end else begin
            rd(vecs[i].addr, vecs[i].be, vecs[i].bs, 0, 0);
            if (vecs[i].exp_err) begin
               check($sformatf("v%0d_err_cyc", i), err_cyc, 1);
               check($sformatf("v%0d_err_cnt", i), errs, 1);
               check($sformatf("v%0d_no_valid", i), vcyc, 0);
               check($sformatf("v%0d_no_end", i), ends, 0);
            end else begin
               check($sformatf("v%0d_first", i), first_cyc, 2);
               check($sformatf("v%0d_beats", i), n, 1);
               check($sformatf("v%0d_data", i), rbuf[0], vecs[i].exp_data);
               check($sformatf("v%0d_end_cyc", i), end_cyc, 3);
               check($sformatf("v%0d_errs", i), errs, 0);
            end
         end
      end

      // 4-beat burst, read back with stalls on data-phase cycles 2-3
      wbuf[0] = 32'h11; wbuf[1] = 32'h22; wbuf[2] = 32'h33; wbuf[3] = 32'h44;
      wr(32'h5000_0100, 4'hF, 8'd3, 4);
      rd(32'h5000_0100, 4'hF, 8'd3, 32'b0110, 0);
      check("burst_beats", n, 4);
      for (int i = 0; i < 4; i++) check($sformatf("burst_d%0d", i), rbuf[i], 32'h11 * (i + 1));
      check("burst_vcyc", vcyc, 6);
      check("burst_end_cyc", end_cyc, 8);
      check("burst_ends", ends, 1);

      // beats past burst_size+1 are dropped
      wbuf[0] = 32'h7777_7777;
      wr(32'h5000_0204, 4'hF, 8'd0, 1);
      wbuf[0] = 32'hAAAA_0001; wbuf[1] = 32'hBBBB_0002;
      wr(32'h5000_0200, 4'hF, 8'd0, 2);
      rd(32'h5000_0200, 4'hF, 8'd1, 0, 0);
      check("over_d0", rbuf[0], 32'hAAAA_0001);
      check("over_d1", rbuf[1], 32'h7777_7777);

      // master abort after beat 3 of 8, then a clean full read
      for (int i = 0; i < 8; i++) wbuf[i] = 32'h100 + i;
      wr(32'h5000_0300, 4'hF, 8'd7, 8);
      rd(32'h5000_0300, 4'hF, 8'd7, 0, 3);
      check("abort_beats", n, 3);
      check("abort_vcyc", vcyc, 3);
      check("abort_ends", ends, 0);
      check("abort_d2", rbuf[2], 32'h102);
      rd(32'h5000_0300, 4'hF, 8'd7, 0, 0);
      check("post_abort_beats", n, 8);
      check("post_abort_d7", rbuf[7], 32'h107);
      check("post_abort_ends", ends, 1);

      // async reset mid read data phase
      for (int i = 0; i < 4; i++) wbuf[i] = 32'hC0DE_0000 + i;
      wr(32'h5000_0400, 4'hF, 8'd3, 4);
      begin_transactionIN = 1; address_dataIN = 32'h5000_0400; byte_enableIN = 4'hF;
      burst_sizeIN = 8'd15; read_n_writeIN = 1;
      step();
      idle_inputs();
      busyIN = 1;
      step();
      check("rst_rd_pre_valid", data_validOUT, 1);
      #2 n_reset = 0;
      #1;
      check("rst_rd_outs", {address_dataOUT, data_validOUT, end_transactionOUT, busyOUT, errorOUT}, 0);
      busyIN = 0;
      #2 n_reset = 1;
      step();

      // async reset mid 16-beat write
      begin_transactionIN = 1; address_dataIN = 32'h5000_0500; byte_enableIN = 4'hF;
      burst_sizeIN = 8'd15; read_n_writeIN = 0;
      step();
      begin_transactionIN = 0;
      data_validIN = 1; address_dataIN = 32'h0BAD_0001; step();
      address_dataIN = 32'h0BAD_0002; step();
      address_dataIN = 32'h0BAD_0003;
      #2 n_reset = 0;
      #1;
      check("rst_wr_outs", {address_dataOUT, data_validOUT, end_transactionOUT, busyOUT, errorOUT}, 0);
      idle_inputs();
      step();
      #2 n_reset = 1;
      step();
      rd(32'h5000_0500, 4'hF, 8'd1, 0, 0);
      check("rst_wr_beats", n, 2);
      check("rst_wr_d0", rbuf[0], 32'h0BAD_0001);
      check("rst_wr_d1", rbuf[1], 32'h0BAD_0002);
      rd(32'h5000_0400, 4'hF, 8'd3, 0, 0);
      check("rst_keep_d0", rbuf[0], 32'hC0DE_0000);
      check("rst_keep_d3", rbuf[3], 32'hC0DE_0003);
      check("rst_keep_ends", ends, 1);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
